// File: rtl/fault_log_buffer.sv
// Circular FIFO for comparison-stage fault log words with first-word fall-through output.
// Dropped words are counted, and a marker word reporting how many were lost is inserted when space allows.
module fault_log_buffer #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     log_write,
    input  logic [63:0]              log_data,
    output logic                     m_valid,
    output logic [63:0]              m_data,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_C     = (AW+1)'(DEPTH);
    localparam logic [AW:0]      MARK_LIM_C = (AW+1)'(DEPTH - 2);
    localparam logic [AW:0]      CNT_ONE_C  = (AW+1)'(1);
    localparam logic [AW-1:0]    PTR_ONE_C  = (AW)'(1);
    localparam logic [CNT_W-1:0] DROP_ONE_C = (CNT_W)'(1);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        MARK = 1'b1
    } state_t;

    logic [63:0]      mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_nx_s;
    logic             overflow_r;
    logic [CNT_W-1:0] drop_cnt_r;
    logic [31:0]      since_r;
    logic             pending_r;
    state_t           state_r;
    state_t           state_nx_s;

    logic        full_s;
    logic        empty_s;
    logic        pop_s;
    logic        push_data_s;
    logic        drop_s;
    logic        mark_push_s;
    logic        push_s;
    logic [63:0] wr_word_s;

    assign full_s      = (count_r == FULL_C);
    assign empty_s     = (count_r == {(AW+1){1'b0}});
    assign pop_s       = !empty_s && m_ready;
    assign push_data_s = log_write && (!full_s || pop_s);
    assign drop_s      = log_write && full_s && !pop_s;
    // Incoming log words always win; the marker only takes an otherwise idle slot.
    assign mark_push_s = (state_r == MARK) && !log_write && (!full_s || pop_s);
    assign push_s      = push_data_s || mark_push_s;
    assign wr_word_s   = push_data_s ? log_data : {32'hFFFF_FFFF, since_r};

    assign m_valid    = !empty_s;
    assign m_data     = empty_s ? 64'h0 : mem_r[rd_ptr_r];
    assign level      = count_r;
    assign overflow   = overflow_r;
    assign drop_count = drop_cnt_r;

    // Occupancy after this edge's push and pop.
    always_comb begin
        count_nx_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nx_s = count_r + CNT_ONE_C;
            2'b01:   count_nx_s = count_r - CNT_ONE_C;
            default: count_nx_s = count_r;
        endcase
    end

    // Marker FSM: arm once a drop is pending and a slot beyond the reserved one is free.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            RUN: begin
                if (pending_r && (count_r <= MARK_LIM_C)) begin
                    state_nx_s = MARK;
                end else begin
                    state_nx_s = RUN;
                end
            end
            MARK: begin
                if (mark_push_s) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = MARK;
                end
            end
            default: state_nx_s = RUN;
        endcase
    end

    // Entry storage; contents need no reset because m_data is masked while empty.
    always_ff @(posedge clock) begin
        if (push_s && !clear) begin
            mem_r[wr_ptr_r] <= wr_word_s;
        end
    end

    // Pointers, occupancy, drop accounting and marker state.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            overflow_r <= 1'b0;
            drop_cnt_r <= {CNT_W{1'b0}};
            since_r    <= 32'h0;
            pending_r  <= 1'b0;
            state_r    <= RUN;
        end else if (clear) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            overflow_r <= 1'b0;
            drop_cnt_r <= {CNT_W{1'b0}};
            since_r    <= 32'h0;
            pending_r  <= 1'b0;
            state_r    <= RUN;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            count_r <= count_nx_s;
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_cnt_r != {CNT_W{1'b1}}) begin
                    drop_cnt_r <= drop_cnt_r + DROP_ONE_C;
                end
            end
            if (mark_push_s) begin
                pending_r <= 1'b0;
                since_r   <= 32'h0;
            end else if (drop_s) begin
                pending_r <= 1'b1;
                if (since_r != 32'hFFFF_FFFF) begin
                    since_r <= since_r + 32'd1;
                end
            end
            state_r <= state_nx_s;
        end
    end

endmodule

// File: tb/tb_fault_log_buffer.sv
// Scoreboard bench for fault_log_buffer: expected words are queued as they are offered
// and compared whenever the consumer accepts the head entry.
module tb_fault_log_buffer;

    logic        clock;
    logic        rst;
    logic        clear;
    logic        log_write;
    logic [63:0] log_data;
    logic        m_valid;
    logic [63:0] m_data;
    logic        m_ready;
    logic [4:0]  level;
    logic        overflow;
    logic [31:0] drop_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] first_w;
    logic [63:0] w;

    fault_log_buffer #(.DEPTH(16), .CNT_W(32)) dut (
        .clock      (clock),
        .rst        (rst),
        .clear      (clear),
        .log_write  (log_write),
        .log_data   (log_data),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .level      (level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] word(input int i);
        return {32'(i + 32'd100), 32'(i * 3 + 7)};
    endfunction

    task automatic wait_drained(input string tag);
        for (int k = 0; k < 60; k++) begin
            if (!m_valid && exp_q.size() == 0) break;
            tick();
        end
        check_eq(tag, {63'd0, (!m_valid && exp_q.size() == 0)}, 64'd1);
    endtask

    // Every accepted head entry is checked against the scoreboard.
    always @(negedge clock) begin
        if (!rst && !clear && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_has_entry", 64'd0, 64'd1);
            end else begin
                check_eq("pop_data", m_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; log_write = 1'b0; log_data = 64'h0; m_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check_eq("rst_valid", {63'd0, m_valid}, 64'd0);
        check_eq("rst_level", 64'(level), 64'd0);
        check_eq("rst_ovf", {63'd0, overflow}, 64'd0);
        check_eq("rst_drops", 64'(drop_count), 64'd0);
        check_eq("rst_data", m_data, 64'h0);

        // single push with consumer ready
        log_write = 1'b1; log_data = 64'h0000_0005_0000_0100; m_ready = 1'b1;
        exp_q.push_back(64'h0000_0005_0000_0100);
        tick();
        log_write = 1'b0;
        check_eq("lat_valid", {63'd0, m_valid}, 64'd1);
        check_eq("lat_data", m_data, 64'h0000_0005_0000_0100);
        tick();
        check_eq("lat_empty_valid", {63'd0, m_valid}, 64'd0);
        check_eq("lat_empty_level", 64'(level), 64'd0);

        // 20 pushes into a stalled consumer
        m_ready = 1'b0;
        first_w = word(0);
        for (int i = 0; i < 20; i++) begin
            log_write = 1'b1; log_data = word(i);
            if (i < 16) exp_q.push_back(word(i));
            tick();
            check_eq("hold_head", m_data, first_w);
        end
        log_write = 1'b0;
        check_eq("full_level", 64'(level), 64'd16);
        check_eq("full_ovf", {63'd0, overflow}, 64'd1);
        check_eq("full_drops", 64'(drop_count), 64'd4);
        exp_q.push_back(64'hFFFF_FFFF_0000_0004);
        m_ready = 1'b1;
        wait_drained("drain_with_marker");
        check_eq("drain_level", 64'(level), 64'd0);

        // simultaneous push and pop with one entry held
        m_ready = 1'b0; log_write = 1'b1; log_data = word(40);
        exp_q.push_back(word(40));
        tick();
        log_data = word(41); m_ready = 1'b1;
        exp_q.push_back(word(41));
        tick();
        log_write = 1'b0;
        check_eq("one_pushpop_level", 64'(level), 64'd1);
        wait_drained("one_drain");

        // push and pop on the same edge while full
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            log_write = 1'b1; log_data = word(50 + i);
            exp_q.push_back(word(50 + i));
            tick();
        end
        check_eq("full2_level", 64'(level), 64'd16);
        log_data = word(70); m_ready = 1'b1;
        exp_q.push_back(word(70));
        tick();
        log_write = 1'b0; m_ready = 1'b0;
        check_eq("full_pushpop_level", 64'(level), 64'd16);
        check_eq("full_pushpop_drops", 64'(drop_count), 64'd4);
        m_ready = 1'b1;
        wait_drained("full2_drain");

        // clear wins over a simultaneous push
        m_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            log_write = 1'b1; log_data = word(80 + i);
            exp_q.push_back(word(80 + i));
            tick();
        end
        log_write = 1'b0;
        check_eq("pre_clear_level", 64'(level), 64'd7);
        clear = 1'b1; log_write = 1'b1; log_data = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        clear = 1'b0; log_write = 1'b0;
        exp_q.delete();
        check_eq("clear_level", 64'(level), 64'd0);
        check_eq("clear_valid", {63'd0, m_valid}, 64'd0);
        check_eq("clear_ovf", {63'd0, overflow}, 64'd0);
        check_eq("clear_drops", 64'(drop_count), 64'd0);
        log_write = 1'b1; log_data = word(90); m_ready = 1'b1;
        exp_q.push_back(word(90));
        tick();
        log_write = 1'b0;
        wait_drained("post_clear_drain");

        // asynchronous reset mid-stream
        m_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            log_write = 1'b1; log_data = word(100 + i);
            if (i < 16) exp_q.push_back(word(100 + i));
            tick();
        end
        log_write = 1'b0;
        check_eq("pre_rst_drops", 64'(drop_count), 64'd1);
        exp_q.push_back(64'hFFFF_FFFF_0000_0001);
        m_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (level == 5'd5) break;
        end
        m_ready = 1'b0;
        check_eq("pre_rst_level", 64'(level), 64'd5);
        check_eq("pre_rst_ovf", {63'd0, overflow}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_valid", {63'd0, m_valid}, 64'd0);
        check_eq("arst_level", 64'(level), 64'd0);
        check_eq("arst_ovf", {63'd0, overflow}, 64'd0);
        check_eq("arst_drops", 64'(drop_count), 64'd0);
        check_eq("arst_data", m_data, 64'h0);
        exp_q.delete();
        #2 rst = 1'b0;
        tick();
        log_write = 1'b1; log_data = word(200); m_ready = 1'b1;
        exp_q.push_back(word(200));
        tick();
        log_write = 1'b0;
        check_eq("post_rst_level", 64'(level), 64'd1);
        wait_drained("post_rst_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
